mac2axis: RTL

MAC2AXIS -- requirements
Module: mac2axis

---
 rtl/mac2axis_pkg.sv | 20 ++
 rtl/mac2axis_rx_ibuf.sv | 25 ++
 rtl/mac2axis.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mac2axis_pkg.sv
// Shared definitions for the MAC receive-to-AXI-Stream bridge: stored word
// layout and the receive FSM state encoding.
package mac2axis_pkg;

    localparam int DATA_W   = 64;
    localparam int KEEP_W   = 8;
    localparam int DW       = 72;
    localparam int KEEP_LSB = 64;
    // tlast rides in one extra bit above the 72-bit tdata+tkeep payload.
    localparam int LAST_BIT = DW;
    localparam int WORD_W   = DW + 1;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2,
        ST_DROP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/mac2axis_rx_ibuf.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered (1-cycle) read.
module rx_ibuf #(
    parameter int AW = 9,
    parameter int DW = 73
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: no reset on the array or read register so this maps onto block RAM;
    // the consumer tracks validity of rd_data separately.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mac2axis.sv
// MAC Rx stream to AXI-Stream bridge: buffers whole frames, publishes only
// frames that end with good status, drops errored and overflowing frames.
module mac2axis
    import mac2axis_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic              s_axis_mac_aclk,
    input  logic              s_axis_mac_aresetn,
    input  logic [DATA_W-1:0] s_axis_mac_tdata,
    input  logic [KEEP_W-1:0] s_axis_mac_tkeep,
    input  logic              s_axis_mac_tvalid,
    input  logic              s_axis_mac_tlast,
    input  logic              s_axis_mac_tuser,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [31:0]       good_frames,
    output logic [31:0]       bad_frames,
    output logic [31:0]       ovf_frames
);

    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    rx_state_t         state, state_nxt;
    logic [AW:0]       wr_ptr, wr_ptr_nxt;
    logic [AW:0]       commit_ptr, commit_nxt;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       fill;
    logic              full, empty;
    logic              wr_en, rd_en, move;
    logic              ram_vld;
    logic              good_inc, bad_inc, ovf_inc;
    logic [WORD_W-1:0] wr_word, rd_word;

    assign fill  = wr_ptr - rd_ptr;
    assign full  = (fill == DEPTH);
    assign empty = (rd_ptr == commit_ptr);

    always_comb begin
        wr_word                       = '0;
        wr_word[DATA_W-1:0]           = s_axis_mac_tdata;
        wr_word[KEEP_LSB +: KEEP_W]   = s_axis_mac_tkeep;
        wr_word[LAST_BIT]             = s_axis_mac_tlast;
    end

    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        commit_nxt = commit_ptr;
        wr_en      = 1'b0;
        good_inc   = 1'b0;
        bad_inc    = 1'b0;
        ovf_inc    = 1'b0;
        case (state)
            ST_SYNC: begin
                if (!s_axis_mac_tvalid) state_nxt = ST_IDLE;
            end
            ST_IDLE, ST_FRAME: begin
                if (s_axis_mac_tvalid) begin
                    if (full) begin
                        wr_ptr_nxt = commit_ptr;
                        ovf_inc    = 1'b1;
                        state_nxt  = s_axis_mac_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        if (s_axis_mac_tlast) begin
                            state_nxt = ST_IDLE;
                            if (s_axis_mac_tuser) begin
                                commit_nxt = wr_ptr + PTR_ONE;
                                good_inc   = 1'b1;
                            end else begin
                                wr_ptr_nxt = commit_ptr;
                                bad_inc    = 1'b1;
                            end
                        end else begin
                            state_nxt = ST_FRAME;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_mac_tvalid && s_axis_mac_tlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    // The RAM read register acts as the prefetch word; it is refilled only
    // when its current contents move into the output stage.
    assign move  = ram_vld && (!m_axis_tvalid || m_axis_tready);
    assign rd_en = !empty && (!ram_vld || move);

    rx_ibuf #(
        .AW (AW),
        .DW (WORD_W)
    ) u_ibuf (
        .clk     (s_axis_mac_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    always_ff @(posedge s_axis_mac_aclk or negedge s_axis_mac_aresetn) begin
        if (!s_axis_mac_aresetn) begin
            state       <= ST_SYNC;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            good_frames <= '0;
            bad_frames  <= '0;
            ovf_frames  <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_nxt;
            if (good_inc) good_frames <= good_frames + 32'd1;
            if (bad_inc)  bad_frames  <= bad_frames + 32'd1;
            if (ovf_inc)  ovf_frames  <= ovf_frames + 32'd1;
        end
    end

    always_ff @(posedge s_axis_mac_aclk or negedge s_axis_mac_aresetn) begin
        if (!s_axis_mac_aresetn) begin
            rd_ptr        <= '0;
            ram_vld       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            ram_vld <= rd_en || (ram_vld && !move);
            if (!m_axis_tvalid || m_axis_tready) begin
                m_axis_tvalid <= ram_vld;
                if (ram_vld) begin
                    m_axis_tdata <= rd_word[DATA_W-1:0];
                    m_axis_tkeep <= rd_word[KEEP_LSB +: KEEP_W];
                    m_axis_tlast <= rd_word[LAST_BIT];
                end
            end
        end
    end

endmodule
